snd_fft_shift4: RTL and testbench

//  Streaming 4-point real-input DFT -> bin remap -> inverse DFT voice-change engine with valid/ready on both sides.

---
 rtl/snd_fft_shift4.sv | 185 ++++++++++++++++++
 tb/tb_snd_fft_shift4.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_fft_shift4.sv
// Streaming 4-point real DFT -> bin rotate/mirror -> inverse DFT voice-change engine.
// Optional saturation counter port SAT_CNT enabled by defining SND_FFT_SATCNT_EN.
module snd_fft_shift4 #(
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] IN_DATA,
    input  logic [1:0]    SHIFT,
    input  logic          MODE,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          BUSY
`ifdef SND_FFT_SATCNT_EN
    ,
    output logic [15:0]   SAT_CNT
`endif
);

    localparam int AW = DW + 4;
    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [AW-1:0] RND  = AW'(2);

    typedef enum logic [1:0] {COLLECT, FWD, INV, EMIT} state_t;

    state_t state, state_n;
    logic [1:0] idx;
    logic       live;
    logic [1:0] shift_q;
    logic       mode_q;
    logic       in_fire, out_fire;

    logic signed [DW-1:0] x_q  [4];
    logic signed [AW-1:0] xr_q [4];
    logic signed [AW-1:0] xi_q [4];
    logic signed [DW-1:0] r_q  [4];
    logic [3:0]           sat_q;

    logic signed [AW-1:0] xe [4];
    logic signed [AW-1:0] fr [4];
    logic signed [AW-1:0] fi [4];
    logic signed [AW-1:0] yr [4];
    logic signed [AW-1:0] yi [4];
    logic signed [AW-1:0] acc, rnd;
    logic signed [DW-1:0] rc [4];
    logic [3:0]           sc;
    logic [1:0]           src;

    // live holds IN_READY low for the first cycle after reset
    assign IN_READY  = (state == COLLECT) && live;
    assign OUT_VALID = (state == EMIT);
    assign OUT_DATA  = (state == EMIT) ? r_q[idx] : '0;
    assign BUSY      = (state != COLLECT);
    assign in_fire   = IN_VALID && IN_READY;
    assign out_fire  = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_X) state <= COLLECT;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            COLLECT: if (in_fire && idx == 2'd3)  state_n = FWD;
            FWD:                                  state_n = INV;
            INV:                                  state_n = EMIT;
            EMIT:    if (out_fire && idx == 2'd3) state_n = COLLECT;
            default:                              state_n = COLLECT;
        endcase
    end

    // Forward transform; X1/X3 are a conjugate pair, X0/X2 purely real.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            xe[i] = {{(AW-DW){x_q[i][DW-1]}}, x_q[i]};
        end
        fr[0] = xe[0] + xe[1] + xe[2] + xe[3];
        fi[0] = '0;
        fr[1] = xe[0] - xe[2];
        fi[1] = xe[3] - xe[1];
        fr[2] = xe[0] - xe[1] + xe[2] - xe[3];
        fi[2] = '0;
        fr[3] = xe[0] - xe[2];
        fi[3] = xe[1] - xe[3];
    end

    // Bin remap, real part of the inverse, round half up, saturate.
    always_comb begin
        src = '0;
        acc = '0;
        rnd = '0;
        sc  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            src   = mode_q ? 2'(4 - k) : 2'(k + 32'(shift_q));
            yr[k] = xr_q[src];
            yi[k] = xi_q[src];
        end
        for (int unsigned n = 0; n < 4; n++) begin
            acc = '0;
            for (int unsigned k = 0; k < 4; k++) begin
                case (2'(k * n))
                    2'd0:    acc = acc + yr[k];
                    2'd1:    acc = acc - yi[k];
                    2'd2:    acc = acc - yr[k];
                    default: acc = acc + yi[k];
                endcase
            end
            rnd = (acc + RND) >>> 2;
            if (rnd > MAXV) begin
                rnd   = MAXV;
                sc[n] = 1'b1;
            end else if (rnd < MINV) begin
                rnd   = MINV;
                sc[n] = 1'b1;
            end
            rc[n] = rnd[DW-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            idx     <= '0;
            live    <= 1'b0;
            shift_q <= '0;
            mode_q  <= 1'b0;
            sat_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                x_q[i]  <= '0;
                xr_q[i] <= '0;
                xi_q[i] <= '0;
                r_q[i]  <= '0;
            end
        end else begin
            live <= 1'b1;
            case (state)
                COLLECT: begin
                    if (in_fire) begin
                        x_q[idx] <= IN_DATA;
                        idx      <= idx + 2'd1;
                        if (idx == 2'd0) begin
                            shift_q <= SHIFT;
                            mode_q  <= MODE;
                        end
                    end
                end
                FWD: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        xr_q[i] <= fr[i];
                        xi_q[i] <= fi[i];
                    end
                end
                INV: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        r_q[i] <= rc[i];
                    end
                    sat_q <= sc;
                end
                EMIT: begin
                    if (out_fire) idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SND_FFT_SATCNT_EN
    logic [15:0] sat_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            sat_cnt <= '0;
        end else if (out_fire && sat_q[idx] && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign SAT_CNT = sat_cnt;
`endif

endmodule

// File: tb/tb_snd_fft_shift4.sv
// Directed and randomized bench for snd_fft_shift4 against a generic 4-point DFT model.
// Checks SAT_CNT as well when SND_FFT_SATCNT_EN is defined.
module tb_snd_fft_shift4;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA = '0;
    logic [1:0]    SHIFT = '0;
    logic          MODE = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] OUT_DATA;
    logic          BUSY;
`ifdef SND_FFT_SATCNT_EN
    logic [15:0]   SAT_CNT;
    int            exp_cnt = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int fx[4];
    int fe[4];
    int fm[4];
    int fs;

    always #5 CLK = ~CLK;

    snd_fft_shift4 #(.DW(DW)) dut (
        .CLK(CLK),
        .RST_X(RST_X),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .IN_DATA(IN_DATA),
        .SHIFT(SHIFT),
        .MODE(MODE),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA),
        .BUSY(BUSY)
`ifdef SND_FFT_SATCNT_EN
        ,
        .SAT_CNT(SAT_CNT)
`endif
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: handshake budget expired", tag);
    endtask

    // Full complex DFT, remap, real inverse, round and clamp.
    task automatic model(input int xs[4], input int s, input int m, output int ys[4], output int nsat);
        int xr[4], xi[4], yr[4], yi[4];
        int src, y, r;
        nsat = 0;
        for (int k = 0; k < 4; k++) begin
            xr[k] = 0;
            xi[k] = 0;
            for (int n = 0; n < 4; n++) begin
                case ((k * n) % 4)
                    0: xr[k] += xs[n];
                    1: xi[k] -= xs[n];
                    2: xr[k] -= xs[n];
                    default: xi[k] += xs[n];
                endcase
            end
        end
        for (int k = 0; k < 4; k++) begin
            src   = (m != 0) ? (4 - k) % 4 : (k + s) % 4;
            yr[k] = xr[src];
            yi[k] = xi[src];
        end
        for (int n = 0; n < 4; n++) begin
            y = 0;
            for (int k = 0; k < 4; k++) begin
                case ((k * n) % 4)
                    0: y += yr[k];
                    1: y -= yi[k];
                    2: y -= yr[k];
                    default: y += yi[k];
                endcase
            end
            r = (y + 2) >>> 2;
            if (r > 32767) begin
                r = 32767;
                nsat++;
            end else if (r < -32768) begin
                r = -32768;
                nsat++;
            end
            ys[n] = r;
        end
    endtask

    task automatic send(input int xs[4], input int s0, input int srest, input int m);
        int  i = 0;
        int  budget = 0;
        bit  fire;
        while (i < 4 && budget < 40) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            IN_DATA  = DW'(xs[i]);
            SHIFT    = 2'((i == 0) ? s0 : srest);
            MODE     = 1'(m);
            fire     = (IN_READY === 1'b1);
            @(posedge CLK);
            if (fire) i++;
            budget++;
        end
        if (i < 4) timeout("send");
    endtask

    task automatic recv(input int exp[4], input bit bp, input bit hold);
        int j = 0;
        int budget = 0;
        bit tog = 1'b1;
        bit rdy;
        @(negedge CLK);
        IN_VALID  = hold;
        OUT_READY = 1'b0;
        check("lat0_out_valid", OUT_VALID, 0);
        check("lat0_busy", BUSY, 1);
        check("lat0_in_ready", IN_READY, 0);
        @(negedge CLK);
        check("lat1_out_valid", OUT_VALID, 0);
        while (j < 4 && budget < 40) begin
            @(negedge CLK);
            check("out_valid", OUT_VALID, 1);
            check("out_data", $signed(OUT_DATA), exp[j]);
            if (hold) check("in_ready_emit", IN_READY, 0);
            OUT_READY = bp ? tog : 1'b1;
            tog       = ~tog;
            rdy       = OUT_READY;
            @(posedge CLK);
            if (rdy) j++;
            budget++;
        end
        if (j < 4) timeout("recv");
        @(negedge CLK);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        check("post_out_valid", OUT_VALID, 0);
        check("post_out_data", $signed(OUT_DATA), 0);
        check("post_busy", BUSY, 0);
        check("post_in_ready", IN_READY, 1);
    endtask

    task automatic run_frame(input int xs[4], input int s0, input int srest, input int m,
                             input bit bp, input bit hold, input int exp[4]);
        int ys[4];
        int nsat;
        model(xs, s0, m, ys, nsat);
        send(xs, s0, srest, m);
        recv(exp, bp, hold);
`ifdef SND_FFT_SATCNT_EN
        exp_cnt += nsat;
        check("sat_cnt", SAT_CNT, exp_cnt);
`endif
    endtask

    initial begin
        // Power-on reset
        RST_X = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_data", $signed(OUT_DATA), 0);
        check("rst_busy", BUSY, 0);
        check("rst_in_ready", IN_READY, 0);
        RST_X = 1'b1;

        // Reset held 3 cycles in the middle of EMIT discards that frame
        fx = '{5, 6, 7, 8};
        send(fx, 0, 0, 0);
        repeat (3) @(negedge CLK);
        check("pre_rst_out_valid", OUT_VALID, 1);
        RST_X    = 1'b0;
        IN_VALID = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("midrst_out_valid", OUT_VALID, 0);
            check("midrst_out_data", $signed(OUT_DATA), 0);
            check("midrst_busy", BUSY, 0);
            check("midrst_in_ready", IN_READY, 0);
        end
        RST_X = 1'b1;
`ifdef SND_FFT_SATCNT_EN
        exp_cnt = 0;
        check("rst_sat_cnt", SAT_CNT, 0);
`endif
        fx = '{1, 2, 3, 4};
        fe = '{1, 2, 3, 4};
        run_frame(fx, 0, 0, 0, 1'b0, 1'b0, fe);

        // S=2 alternates sign
        fx = '{100, 200, 300, 400};
        fe = '{100, -200, 300, -400};
        run_frame(fx, 2, 2, 0, 1'b0, 1'b0, fe);

        // Odd rotations keep even samples, one negated; mirror reverses 1..3
        fx = '{10, 20, 30, 40};
        fe = '{10, 0, -30, 0};
        run_frame(fx, 1, 1, 0, 1'b0, 1'b0, fe);
        run_frame(fx, 3, 3, 0, 1'b0, 1'b0, fe);
        fe = '{10, 40, 30, 20};
        run_frame(fx, 0, 0, 1, 1'b0, 1'b0, fe);

        // Saturation on negated most-negative samples
        fx = '{-32768, -32768, -32768, -32768};
        fe = '{-32768, 32767, -32768, 32767};
        run_frame(fx, 2, 2, 0, 1'b0, 1'b0, fe);

        // Backpressure with IN_VALID held high through EMIT
        fx = '{-7, 1234, -32768, 32767};
        fe = '{-7, -1234, -32768, -32767};
        run_frame(fx, 2, 2, 0, 1'b1, 1'b1, fe);

        // SHIFT change after sample 0 is ignored until the next frame
        fx = '{11, 22, 33, 44};
        fe = '{11, 22, 33, 44};
        run_frame(fx, 0, 2, 0, 1'b0, 1'b0, fe);
        fe = '{11, -22, 33, -44};
        run_frame(fx, 2, 2, 0, 1'b0, 1'b0, fe);

        // Randomized frames against the model
        for (int f = 0; f < 12; f++) begin
            int s, m, nsat;
            bit bp, hold;
            for (int i = 0; i < 4; i++) begin
                logic signed [15:0] v;
                v     = 16'($urandom);
                fx[i] = v;
            end
            if (f % 4 == 3) fx[$urandom_range(3)] = -32768;
            s    = $urandom_range(3);
            m    = $urandom_range(1);
            bp   = 1'($urandom_range(1));
            hold = 1'($urandom_range(1));
            model(fx, s, m, fm, nsat);
            fs = nsat;
            run_frame(fx, s, $urandom_range(3), m, bp, hold, fm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
